// File: rtl/obi_tcm_router.sv
// rtl/obi_tcm_router.sv - in-order OBI data-port router between I-TCM and D-TCM banks
module obi_tcm_router #(
    parameter int SEL_BIT   = 31,
    parameter int MAX_OUTST = 2,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             core_req_i,
    output logic             core_gnt_o,
    output logic             core_rvalid_o,
    input  logic             core_we_i,
    input  logic [3:0]       core_be_i,
    input  logic [31:0]      core_addr_i,
    input  logic [31:0]      core_wdata_i,
    output logic [31:0]      core_rdata_o,

    output logic             itcm_req_o,
    input  logic             itcm_gnt_i,
    input  logic             itcm_rvalid_i,
    output logic             itcm_we_o,
    output logic [3:0]       itcm_be_o,
    output logic [31:0]      itcm_addr_o,
    output logic [31:0]      itcm_wdata_o,
    input  logic [31:0]      itcm_rdata_i,

    output logic             dtcm_req_o,
    input  logic             dtcm_gnt_i,
    input  logic             dtcm_rvalid_i,
    output logic             dtcm_we_o,
    output logic [3:0]       dtcm_be_o,
    output logic [31:0]      dtcm_addr_o,
    output logic [31:0]      dtcm_wdata_o,
    input  logic [31:0]      dtcm_rdata_i,

    output logic [CNT_W-1:0] outst_o,
    output logic             bad_rsp_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_tgt_q, last_tgt_d;
    logic             bad_rsp_q, bad_rsp_d;

    logic tgt;
    logic cnt_zero;
    logic allowed;
    logic sel_gnt;
    logic last_rvalid;
    logic other_rvalid;
    logic rsp_fire;

    always_comb begin
        tgt         = core_addr_i[SEL_BIT];
        cnt_zero    = (cnt_q == '0);
        // A target switch is only legal once every response from the old bank has drained.
        allowed     = core_req_i && (cnt_q < CNT_MAX) && (cnt_zero || (tgt == last_tgt_q));
        sel_gnt     = tgt ? dtcm_gnt_i : itcm_gnt_i;
        last_rvalid = last_tgt_q ? dtcm_rvalid_i : itcm_rvalid_i;
        other_rvalid = last_tgt_q ? itcm_rvalid_i : dtcm_rvalid_i;
        rsp_fire    = !cnt_zero && last_rvalid;
    end

    assign itcm_req_o    = allowed && !tgt;
    assign dtcm_req_o    = allowed && tgt;
    assign core_gnt_o    = allowed && sel_gnt;
    assign core_rvalid_o = rsp_fire;
    assign core_rdata_o  = last_tgt_q ? dtcm_rdata_i : itcm_rdata_i;

    assign itcm_we_o     = core_we_i;
    assign itcm_be_o     = core_be_i;
    assign itcm_addr_o   = core_addr_i;
    assign itcm_wdata_o  = core_wdata_i;
    assign dtcm_we_o     = core_we_i;
    assign dtcm_be_o     = core_be_i;
    assign dtcm_addr_o   = core_addr_i;
    assign dtcm_wdata_o  = core_wdata_i;

    assign outst_o       = cnt_q;
    assign bad_rsp_o     = bad_rsp_q;

    always_comb begin
        cnt_d      = cnt_q;
        last_tgt_d = last_tgt_q;
        if (core_gnt_o) begin
            last_tgt_d = tgt;
        end
        case ({core_gnt_o, rsp_fire})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        // Responses from the wrong bank, or with nothing outstanding, are dropped and flagged.
        bad_rsp_d = other_rvalid || (cnt_zero && last_rvalid);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            last_tgt_q <= 1'b0;
            bad_rsp_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            last_tgt_q <= last_tgt_d;
            bad_rsp_q  <= bad_rsp_d;
        end
    end

endmodule

// File: doc/obi_tcm_router.md
Name: obi_tcm_router

Overview:
- Sits directly downstream of the core's OBI data port and replaces the purely combinational TCM partition steering.
- Routes each core data transaction to the I-TCM or D-TCM bank port, selected by one address bit.
- Tracks outstanding transactions and returns responses to the core strictly in order.
- Blocks any target switch until all responses from the previous target have drained, so the two banks can never reorder responses.

Parameters:
- SEL_BIT, 31, address bit that selects the bank: 0 = I-TCM, 1 = D-TCM.
- MAX_OUTST, 2, maximum granted-but-unanswered transactions (1..15).
- CNT_W, $clog2(MAX_OUTST+1), width of the outstanding counter (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  OBI request from core
- core_gnt_o  out  1  OBI grant to core
- core_rvalid_o  out  1  OBI response valid to core
- core_we_i  in  1  write enable
- core_be_i  in  4  byte enables
- core_addr_i  in  32  address
- core_wdata_i  in  32  write data
- core_rdata_o  out  32  read data to core
- itcm_req_o / dtcm_req_o  out  1  bank request
- itcm_gnt_i / dtcm_gnt_i  in  1  bank grant
- itcm_rvalid_i / dtcm_rvalid_i  in  1  bank response valid
- itcm_we_o / dtcm_we_o  out  1  bank write enable
- itcm_be_o / dtcm_be_o  out  4  bank byte enables
- itcm_addr_o / dtcm_addr_o  out  32  bank address (full, unmodified)
- itcm_wdata_o / dtcm_wdata_o  out  32  bank write data
- itcm_rdata_i / dtcm_rdata_i  in  32  bank read data
- outst_o  out  CNT_W  current outstanding count
- bad_rsp_o  out  1  one-cycle pulse on an unexpected bank response

Behaviour:
- One clock. Reset is asynchronous and active-low: the clock port is clk_i and the reset port is rst_ni.
- State: cnt (CNT_W bits), last_tgt (1 bit), bad_rsp register.
  - Reset values: cnt=0, last_tgt=0, bad_rsp_o=0.
  - All outputs are combinational from state and inputs, except bad_rsp_o, which is registered.
- Decode: tgt = core_addr_i[SEL_BIT].
- Issue allowed when core_req_i=1 AND cnt<MAX_OUTST AND (cnt==0 OR tgt==last_tgt).
- Request path:
  - The selected bank's req_o follows core_req_i only when issue is allowed; the unselected bank's req_o is 0.
  - we, be, addr and wdata are broadcast to both banks unchanged, with zero added latency.
- core_gnt_o = allowed AND selected bank gnt_i. A blocked request sees gnt=0; the core holds its request stable, per OBI.
- On a grant (core_req_i & core_gnt_o): last_tgt <= tgt.
- Response path:
  - core_rvalid_o = (cnt>0) AND rvalid_i of bank last_tgt.
  - core_rdata_o = rdata_i of bank last_tgt. The value is don't-care unless core_rvalid_o=1; the mux follows last_tgt regardless.
- Counter updates:
  - Grant only: cnt+1.
  - Forwarded rvalid only: cnt-1.
  - Both in the same cycle: cnt unchanged.
- Same-cycle rvalid for a just-granted transaction is not supported; banks have at least 1 cycle of response latency.
- Full condition: cnt==MAX_OUTST blocks issue even to the same target. A response and a new grant in the same cycle at full is not possible, since issue is blocked at full.
- Target switch: a request to the other bank waits until cnt==0. It may be granted in the same cycle the last response returns only if cnt is already 0 at the start of that cycle; no combinational look-ahead.
- Unexpected response:
  - Triggered by rvalid_i from the non-last_tgt bank, or any rvalid_i while cnt==0.
  - The response is dropped, cnt is unchanged, and bad_rsp_o=1 in the next cycle for exactly one cycle.
  - If both banks assert rvalid together with cnt>0, the last_tgt response is forwarded and the other is flagged.
- Reset mid-operation clears cnt and last_tgt immediately. Responses arriving after reset are flagged as unexpected.

Test Plan:
- Reset, then a read at 0x0000_0100 with itcm gnt same cycle and rvalid 1 cycle later, rdata 0xA5A5A5A5 -> itcm_req_o=1, core_gnt_o=1, outst_o=1, then core_rvalid_o=1, core_rdata_o=0xA5A5A5A5, outst_o=0; dtcm_req_o stays 0.
- Two back-to-back writes to 0x8000_0000 and 0x8000_0004 with dtcm gnt=1 and rvalid delayed 3 cycles -> both granted, outst_o reaches 2; a third dtcm request is held with gnt=0 until the first rvalid.
- D-TCM read outstanding (0x8000_0010), then a request to 0x0000_0010 -> core_gnt_o=0 and itcm_req_o=0 until the dtcm rvalid returns; granted the following cycle; last_tgt=0.
- Grant and rvalid in the same cycle with outst_o=1 on the same bank -> outst_o stays 1.
- itcm_rvalid_i pulsed while outst_o=0 -> core_rvalid_o=0, bad_rsp_o=1 for exactly one cycle next cycle.
- rst_ni asserted with outst_o=2 -> outst_o=0 and bad_rsp_o=0 asynchronously; the first post-reset request to either bank is granted without stall.
